// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin arbiter sharing one data-memory port between
// m0 (CPU load/store) and m1 (DMA/loader), with a bounded burst length under
// contention. The memory reads combinationally and writes on the closing edge,
// so every granted cycle with the owner's req high is one complete beat.
//
// Optional feature: define DMEM_ARB_ADDR_CHECK_EN to enable address checking.
// A misaligned or out-of-range beat has its write suppressed, its read data
// zeroed, and sets the sticky err flag.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   mX_req/we/addr/wd                requester X access (X = 0, 1)
//   mX_gnt                           requester X owns the port (registered)
//   mX_rd                            read data for requester X (0 when not its beat)
//   mem_we/addr/wd, mem_rd           memory port
//   busy                             arbiter not idle
//   err                              sticky address fault (0 without the feature)
module dmem_port_arbiter #(
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_gnt,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_gnt,
  output logic [31:0] m1_rd,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  // Reject unusable configurations at elaboration.
  if (MAX_BURST < 1 || DEPTH_WORDS < 1) begin : g_bad_cfg
    $error("dmem_port_arbiter: MAX_BURST and DEPTH_WORDS must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             beat0, beat1;
  logic             fault0, fault1;

  assign beat0 = (state == OWN0) && m0_req;
  assign beat1 = (state == OWN1) && m1_req;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  // A fault is a misaligned address or a word index beyond the memory.
  assign fault0 = beat0 && ((m0_addr[1:0] != 2'b00) ||
                            ({2'b00, m0_addr[31:2]} >= 32'(DEPTH_WORDS)));
  assign fault1 = beat1 && ((m1_addr[1:0] != 2'b00) ||
                            ({2'b00, m1_addr[31:2]} >= 32'(DEPTH_WORDS)));

  logic err_q;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (fault0 || fault1) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign fault0 = 1'b0;
  assign fault1 = 1'b0;
  assign err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next-state, ownership bookkeeping and burst counting.
  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    beat_cnt_nxt = beat_cnt;

    unique case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = last ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_req)                              state_nxt = m1_req ? OWN1 : IDLE;
        else if (beat_cnt == LAST_BEAT && m1_req) state_nxt = OWN1;
      end
      OWN1: begin
        if (!m1_req)                              state_nxt = m0_req ? OWN0 : IDLE;
        else if (beat_cnt == LAST_BEAT && m0_req) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase

    // Any ownership change restarts the count; otherwise count beats, saturating.
    if (state_nxt != state) begin
      beat_cnt_nxt = '0;
      if (state_nxt == OWN0) last_nxt = 1'b0;
      if (state_nxt == OWN1) last_nxt = 1'b1;
    end else if ((beat0 || beat1) && beat_cnt != LAST_BEAT) begin
      beat_cnt_nxt = beat_cnt + CNT_W'(1);
    end
  end

  assign m0_gnt = (state == OWN0);
  assign m1_gnt = (state == OWN1);
  assign busy   = (state != IDLE);

  // Memory port mux; everything is zero outside a beat, so reset kills a write at once.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = 32'h0;
    mem_wd   = 32'h0;
    m0_rd    = 32'h0;
    m1_rd    = 32'h0;
    if (beat0) begin
      mem_we   = m0_we && !fault0;
      mem_addr = m0_addr;
      mem_wd   = m0_wd;
      m0_rd    = fault0 ? 32'h0 : mem_rd;
    end else if (beat1) begin
      mem_we   = m1_we && !fault1;
      mem_addr = m1_addr;
      mem_wd   = m1_wd;
      m1_rd    = fault1 ? 32'h0 : mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed bench for dmem_port_arbiter (MAX_BURST=4)
// with a small behavioural memory (combinational read, clocked write).
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic        m0_gnt, m1_gnt;
  logic [31:0] m0_rd, m1_rd;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        busy, err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wd;
  end

  dmem_port_arbiter #(.MAX_BURST(4), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rd(m1_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0;

    // Reset state
    #3;
    chk("rst_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_mem", {31'h0, mem_we} | mem_addr | mem_wd | m0_rd | m1_rd, 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Single master write then read back
    cyc();
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wd = 32'hDEADBEEF;
    #2;
    chk("t1_c0_gnt", {31'h0, m0_gnt}, 32'h0);
    chk("t1_c0_we", {31'h0, mem_we}, 32'h0);
    cyc(); #2;
    chk("t1_c1_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("t1_c1_we", {31'h0, mem_we}, 32'h1);
    chk("t1_c1_addr", mem_addr, 32'h10);
    chk("t1_c1_wd", mem_wd, 32'hDEADBEEF);
    cyc();
    m0_we = 0;
    #2;
    chk("t1_rd", m0_rd, 32'hDEADBEEF);
    chk("t1_rd1", m1_rd, 32'h0);
    cyc();
    m0_req = 0;
    #2;
    chk("t1_rel_busy", {31'h0, busy}, 32'h1);
    chk("t1_rel_addr", mem_addr, 32'h0);
    chk("t1_rel_rd", m0_rd, 32'h0);
    cyc(); #2;
    chk("t1_idle", {30'h0, busy, m0_gnt}, 32'h0);

    // Tie after reset: m0 first, handoff without bubble
    rst_n = 0; #1; rst_n = 1;
    cyc();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    #2;
    chk("t2_c0_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    cyc(); #2;
    chk("t2_c1_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    cyc(); #2;
    chk("t2_c2_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    cyc();
    m0_req = 0;
    #2;
    chk("t2_rel_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    chk("t2_rel_addr", mem_addr, 32'h0);
    cyc(); #2;
    chk("t2_hand_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h2);
    chk("t2_hand_rd1", m1_rd, 32'hDEADBEEF);
    chk("t2_hand_rd0", m0_rd, 32'h0);
    cyc();
    m1_req = 0;
    cyc(); #2;
    chk("t2_idle", {31'h0, busy}, 32'h0);

    // Burst limit under continuous contention: 4 m0, 4 m1, repeating
    cyc();
    m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wd = 32'hA0A0_0001;
    m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wd = 32'hB0B0_0001;
    for (int k = 1; k <= 16; k++) begin
      logic own1;
      cyc(); #2;
      own1 = (((k - 1) / 4) % 2) == 1;
      chk($sformatf("t3_gnt_%0d", k), {30'h0, m1_gnt, m0_gnt}, own1 ? 32'h2 : 32'h1);
      chk($sformatf("t3_addr_%0d", k), mem_addr, own1 ? 32'h80 : 32'h40);
      chk($sformatf("t3_wd_%0d", k), mem_wd, own1 ? 32'hB0B0_0001 : 32'hA0A0_0001);
    end
    cyc();
    m0_req = 0; m1_req = 0;
    #2;
    chk("t3_rel_we", {31'h0, mem_we}, 32'h0);
    cyc(); #2;
    chk("t3_idle", {31'h0, busy}, 32'h0);

    // Uncontended 20-cycle burst by m1
    cyc();
    m1_req = 1; m1_we = 0; m1_addr = 32'h80;
    for (int k = 1; k <= 20; k++) begin
      cyc(); #2;
      chk($sformatf("t4_gnt_%0d", k), {29'h0, busy, m1_gnt, m0_gnt}, 32'h6);
      chk($sformatf("t4_rd_%0d", k), m1_rd, 32'hB0B0_0001);
    end
    cyc();
    m1_req = 0;
    #2;
    chk("t4_rel", {29'h0, busy, m1_gnt, m0_gnt}, 32'h6);
    chk("t4_rel_rd", m1_rd, 32'h0);
    cyc(); #2;
    chk("t4_idle", {29'h0, busy, m1_gnt, m0_gnt}, 32'h0);

    // Reset during an m1 write beat
    cyc();
    m1_req = 1; m1_we = 1; m1_addr = 32'h100; m1_wd = 32'h0000_0055;
    cyc(); #2;
    chk("t5_beat", {30'h0, mem_we, m1_gnt}, 32'h3);
    rst_n = 0;
    #1;
    chk("t5_async", {29'h0, busy, mem_we, m1_gnt}, 32'h0);
    cyc();
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h100;
    rst_n = 1;
    cyc(); #2;
    chk("t5_tie", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    chk("t5_nocommit", m0_rd, 32'h0);
    cyc();
    m0_req = 0; m1_req = 0;
    cyc();
    m1_req = 0;
    cyc(); #2;
    chk("t5_idle", {31'h0, busy}, 32'h0);

    // Address range check
    m0_req = 1; m0_we = 1; m0_addr = 32'h1000; m0_wd = 32'h0000_CAFE;
    #2;
    chk("t6_c0_err", {31'h0, err}, 32'h0);
    cyc(); #2;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    chk("t6_fault_we", {31'h0, mem_we}, 32'h0);
    chk("t6_fault_err", {31'h0, err}, 32'h0);
`else
    chk("t6_pass_we", {31'h0, mem_we}, 32'h1);
    chk("t6_pass_addr", mem_addr, 32'h1000);
`endif
    cyc();
    m0_addr = 32'h0FFC; m0_wd = 32'h0000_1234;
    #2;
    chk("t6_ok_we", {31'h0, mem_we}, 32'h1);
`ifdef DMEM_ARB_ADDR_CHECK_EN
    chk("t6_err_set", {31'h0, err}, 32'h1);
`else
    chk("t6_err_zero", {31'h0, err}, 32'h0);
`endif
    cyc();
    m0_we = 0;
    #2;
    chk("t6_rdback", m0_rd, 32'h0000_1234);
    cyc();
    m0_req = 0;
    cyc(); #2;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    chk("t6_err_sticky", {31'h0, err}, 32'h1);
`else
    chk("t6_err_still0", {31'h0, err}, 32'h0);
`endif
    chk("t6_idle", {31'h0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
